// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multicycle controller and its datapath.
//   master : datapath / sequencer side - drives run, instruction fields and
//            mem_ready; observes the control strobes and status.
//   slave  : controller side - the mirror image.
// Signals:
//   run, opcode[6:0], funct3[2:0], funct7[6:0], mem_ready  (to controller)
//   pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write,
//   alu_cc[ALU_CC_W-1:0], state[2:0], halted, err_code[1:0] (from controller)
// Optional macro MC_PERF_COUNTERS_EN adds retired_cnt/stall_cnt[CNT_W-1:0].
interface multicycle_ctrl_if #(
  parameter int ALU_CC_W = 4
`ifdef MC_PERF_COUNTERS_EN
  , parameter int CNT_W  = 32
`endif
);
  logic                run;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                reg_write;
  logic                mem2reg;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic [ALU_CC_W-1:0] alu_cc;
  logic [2:0]          state;
  logic                halted;
  logic [1:0]          err_code;
`ifdef MC_PERF_COUNTERS_EN
  logic [CNT_W-1:0]    retired_cnt;
  logic [CNT_W-1:0]    stall_cnt;
`endif

  modport master (
    output run, opcode, funct3, funct7, mem_ready,
    input  pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read,
           mem_write, alu_cc, state, halted, err_code
`ifdef MC_PERF_COUNTERS_EN
    , input retired_cnt, stall_cnt
`endif
  );

  modport slave (
    input  run, opcode, funct3, funct7, mem_ready,
    output pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read,
           mem_write, alu_cc, state, halted, err_code
`ifdef MC_PERF_COUNTERS_EN
    , output retired_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB) with a memory
// ready handshake, a memory-wait timeout and a sticky halt.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-low reset
//   bus    - multicycle_ctrl_if.slave: run/opcode/funct3/funct7/mem_ready in;
//            control strobes, alu_cc, state, halted, err_code out
// Optional macro MC_PERF_COUNTERS_EN adds retired/stall performance counters.
//
// state  | meaning
// IDLE 0 | waiting for run
// FETCH 1| ir_write + pc_write
// DECODE2| latch instruction fields, check opcode
// EXEC 3 | ALU operation
// MEM 4  | LW/SW access, wait for mem_ready (with timeout)
// WB 5   | register write-back
// HALT 7 | sticky error stop, left only by reset
module multicycle_ctrl #(
  parameter int ALU_CC_W    = 4,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 16
`ifdef MC_PERF_COUNTERS_EN
  , parameter int CNT_W     = 32
`endif
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(0);
  localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(1);
  localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(2);
  localparam logic [ALU_CC_W-1:0] CC_XOR = ALU_CC_W'(3);
  localparam logic [ALU_CC_W-1:0] CC_SLL = ALU_CC_W'(4);
  localparam logic [ALU_CC_W-1:0] CC_SRL = ALU_CC_W'(5);
  localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(6);
  localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(7);
  localparam logic [ALU_CC_W-1:0] CC_SRA = ALU_CC_W'(8);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  logic [2:0]      state_q, state_d;
  logic [1:0]      err_q, err_d;
  logic [6:0]      op_q, op_d;
  logic [2:0]      f3_q, f3_d;
  logic [6:0]      f7_q, f7_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Only funct7[5] selects between operation variants.
  logic unused_f7;
  assign unused_f7 = ^{f7_q[6], f7_q[4:0]};

  logic is_r, is_i, is_lw, is_sw;
  assign is_r  = (op_q == OP_R);
  assign is_i  = (op_q == OP_I);
  assign is_lw = (op_q == OP_LW);
  assign is_sw = (op_q == OP_SW);

  logic op_legal;
  assign op_legal = (bus.opcode == OP_R) || (bus.opcode == OP_I) ||
                    (bus.opcode == OP_LW) || (bus.opcode == OP_SW);

  // The limit is hit on the cycle whose increment would reach MEM_TIMEOUT,
  // so exactly MEM_TIMEOUT MEM cycles are spent before halting.
  logic [TO_W:0] to_next;
  logic          timeout_hit;
  assign to_next     = {1'b0, to_cnt_q} + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_next == (TO_W+1)'(MEM_TIMEOUT));

  // ALU code from the latched fields; also held in WB.
  logic [ALU_CC_W-1:0] cc_op;
  always_comb begin
    cc_op = CC_ADD;
    if (is_r || is_i) begin
      case (f3_q)
        3'b000:  cc_op = (is_r && f7_q[5]) ? CC_SUB : CC_ADD;
        3'b001:  cc_op = CC_SLL;
        3'b010:  cc_op = CC_SLT;
        3'b011:  cc_op = CC_SLT;
        3'b100:  cc_op = CC_XOR;
        3'b101:  cc_op = f7_q[5] ? CC_SRA : CC_SRL;
        3'b110:  cc_op = CC_OR;
        default: cc_op = CC_AND;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    op_d     = op_q;
    f3_d     = f3_q;
    f7_d     = f7_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        f3_d = bus.funct3;
        f7_d = bus.funct7;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        to_cnt_d = '0;
        state_d  = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (is_lw)        state_d = S_WB;
          else if (bus.run) state_d = S_FETCH;
          else              state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (timeout_hit) begin
            state_d = S_HALT;
            err_d   = ERR_TIMEOUT;
          end
        end
      end
      S_WB:     state_d = bus.run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = ERR_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      err_q    <= ERR_NONE;
      op_q     <= '0;
      f3_q     <= '0;
      f7_q     <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      op_q     <= op_d;
      f3_q     <= f3_d;
      f7_q     <= f7_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    bus.pc_write  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem2reg   = 1'b0;
    bus.alu_src   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_cc    = CC_AND;
    case (state_q)
      S_FETCH: begin
        bus.pc_write = 1'b1;
        bus.ir_write = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src = !is_r;
        bus.alu_cc  = cc_op;
      end
      S_MEM: begin
        bus.alu_src   = 1'b1;
        bus.alu_cc    = CC_ADD;
        bus.mem_read  = is_lw;
        bus.mem_write = is_sw;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.mem2reg   = is_lw;
        bus.alu_src   = !is_r;
        bus.alu_cc    = cc_op;
      end
      default: ;
    endcase
  end

  assign bus.state    = state_q;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.err_code = err_q;

`ifdef MC_PERF_COUNTERS_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Both events only occur in WB/MEM, so the counters freeze in HALT.
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if ((state_q == S_WB) || (state_q == S_MEM && bus.mem_ready && is_sw))
      retired_d = retired_q + 1'b1;
    if (state_q == S_MEM && !bus.mem_ready)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_ctrl_if #(.ALU_CC_W(4)) bus ();
  multicycle_ctrl #(.ALU_CC_W(4), .TO_W(8), .MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  // strobe vector order: {pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write}
  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_FETCH = 7'b1100000;
  localparam logic [6:0] SB_SRC   = 7'b0000100;
  localparam logic [6:0] SB_RD    = 7'b0000110;
  localparam logic [6:0] SB_WR    = 7'b0000101;
  localparam logic [6:0] SB_WB_R  = 7'b0010000;
  localparam logic [6:0] SB_WB_I  = 7'b0010100;
  localparam logic [6:0] SB_WB_LW = 7'b0011100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [6:0] sb,
                         input logic [3:0] cc, input logic h, input logic [1:0] e);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".strobes"}, 32'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem2reg,
                                 bus.alu_src, bus.mem_read, bus.mem_write}), 32'(sb));
    chk({tag, ".alu_cc"}, 32'(bus.alu_cc), 32'(cc));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
    chk({tag, ".err"}, 32'(bus.err_code), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; bus.run = 1'b0; bus.opcode = 7'd0; bus.funct3 = 3'd0;
    bus.funct7 = 7'd0; bus.mem_ready = 1'b0;
    step(); step();
    chk_out("reset", 3'd0, SB_NONE, 4'h0, 1'b0, 2'b00);

    // ADD
    reset = 1'b1; bus.run = 1'b1; bus.opcode = OP_R; bus.funct3 = 3'b000; bus.funct7 = 7'b0000000;
    step(); chk_out("add.fetch", 3'd1, SB_FETCH, 4'h0, 1'b0, 2'b00);
    step(); chk_out("add.decode", 3'd2, SB_NONE, 4'h0, 1'b0, 2'b00);
    step(); chk_out("add.exec", 3'd3, SB_NONE, 4'h2, 1'b0, 2'b00);
    step(); chk_out("add.wb", 3'd5, SB_WB_R, 4'h2, 1'b0, 2'b00);
    // SUB
    bus.funct7 = 7'b0100000;
    step(); chk_out("sub.fetch", 3'd1, SB_FETCH, 4'h0, 1'b0, 2'b00);
    step(); chk_out("sub.decode", 3'd2, SB_NONE, 4'h0, 1'b0, 2'b00);
    step(); chk_out("sub.exec", 3'd3, SB_NONE, 4'h6, 1'b0, 2'b00);
    step(); chk_out("sub.wb", 3'd5, SB_WB_R, 4'h6, 1'b0, 2'b00);

    // LW, ready on 3rd MEM cycle (7 cycles total)
    bus.opcode = OP_LW; bus.funct3 = 3'b010; bus.funct7 = 7'd0;
    step(); chk_out("lw.fetch", 3'd1, SB_FETCH, 4'h0, 1'b0, 2'b00);
    step(); chk_out("lw.decode", 3'd2, SB_NONE, 4'h0, 1'b0, 2'b00);
    step(); chk_out("lw.exec", 3'd3, SB_SRC, 4'h2, 1'b0, 2'b00);
    step(); chk_out("lw.mem1", 3'd4, SB_RD, 4'h2, 1'b0, 2'b00);
    step(); chk_out("lw.mem2", 3'd4, SB_RD, 4'h2, 1'b0, 2'b00);
    step(); chk_out("lw.mem3", 3'd4, SB_RD, 4'h2, 1'b0, 2'b00);
    bus.mem_ready = 1'b1;
    step(); chk_out("lw.wb", 3'd5, SB_WB_LW, 4'h2, 1'b0, 2'b00);
    bus.mem_ready = 1'b0;

    // SW, ready on 1st MEM cycle with run dropped -> IDLE
    bus.opcode = OP_SW;
    step(); chk_out("sw.fetch", 3'd1, SB_FETCH, 4'h0, 1'b0, 2'b00);
    step(); chk_out("sw.decode", 3'd2, SB_NONE, 4'h0, 1'b0, 2'b00);
    step(); chk_out("sw.exec", 3'd3, SB_SRC, 4'h2, 1'b0, 2'b00);
    step(); chk_out("sw.mem1", 3'd4, SB_WR, 4'h2, 1'b0, 2'b00);
    bus.run = 1'b0; bus.mem_ready = 1'b1;
    step(); chk_out("sw.idle", 3'd0, SB_NONE, 4'h0, 1'b0, 2'b00);
    bus.mem_ready = 1'b0;
    step(); chk_out("sw.idle_hold", 3'd0, SB_NONE, 4'h0, 1'b0, 2'b00);

    // I-ALU: funct3 000 is ADD even with funct7[5]=1; funct3 101 with funct7[5] is SRA
    bus.run = 1'b1; bus.opcode = OP_I; bus.funct3 = 3'b000; bus.funct7 = 7'b0100000;
    step(); step();
    step(); chk_out("addi.exec", 3'd3, SB_SRC, 4'h2, 1'b0, 2'b00);
    step(); chk_out("addi.wb", 3'd5, SB_WB_I, 4'h2, 1'b0, 2'b00);
    bus.funct3 = 3'b101;
    step(); step();
    step(); chk_out("srai.exec", 3'd3, SB_SRC, 4'h8, 1'b0, 2'b00);
    step(); chk_out("srai.wb", 3'd5, SB_WB_I, 4'h8, 1'b0, 2'b00);

    // Illegal opcode -> sticky HALT
    bus.opcode = 7'b1101111;
    step(); chk_out("ill.fetch", 3'd1, SB_FETCH, 4'h0, 1'b0, 2'b00);
    step(); chk_out("ill.decode", 3'd2, SB_NONE, 4'h0, 1'b0, 2'b00);
    step(); chk_out("ill.halt", 3'd7, SB_NONE, 4'h0, 1'b1, 2'b01);
    bus.opcode = OP_R;
    step(); step(); step();
    chk_out("ill.halt_hold", 3'd7, SB_NONE, 4'h0, 1'b1, 2'b01);

    // Reset out of HALT
    reset = 1'b0;
    step(); step();
    chk_out("rst_halt", 3'd0, SB_NONE, 4'h0, 1'b0, 2'b00);

    // LW timeout: 16 MEM cycles then HALT err 10
    reset = 1'b1; bus.opcode = OP_LW; bus.mem_ready = 1'b0;
    step(); step(); step();
    chk_out("to.exec", 3'd3, SB_SRC, 4'h2, 1'b0, 2'b00);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("to.mem%0d.state", i), 32'(bus.state), 32'd4);
    end
    step(); chk_out("to.halt", 3'd7, SB_NONE, 4'h0, 1'b1, 2'b10);

    // Ready on the 16th MEM cycle wins over the timeout
    reset = 1'b0; step(); step();
    reset = 1'b1;
    step(); step(); step();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("tr.mem%0d.mem_read", i), 32'(bus.mem_read), 32'd1);
    end
    bus.mem_ready = 1'b1;
    step(); chk_out("tr.wb", 3'd5, SB_WB_LW, 4'h2, 1'b0, 2'b00);
    bus.mem_ready = 1'b0;

    // Reset in the middle of MEM drops the strobe on the next cycle
    step(); step(); step();
    step(); chk_out("mr.mem", 3'd4, SB_RD, 4'h2, 1'b0, 2'b00);
    reset = 1'b0;
    step(); chk_out("mr.reset", 3'd0, SB_NONE, 4'h0, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
